// File: rtl/word_rx_pkg.sv
// word_rx_pkg: shared constants and types for the word_rx serial receiver.
//   - ASCII encodings of the four recognised words and the space terminator
//   - word lengths and word_id encodings
//   - receiver FSM state enum
//   - helpers word_char()/word_len() that look up a word's character or length by id
package word_rx_pkg;

  localparam int NUM_WORDS = 4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Each word is padded to 16 characters so any 4-bit index stays in range.
  localparam logic [0:15][7:0] WORD_ENG  = {"ENGINEERING", 40'h0};
  localparam logic [0:15][7:0] WORD_ASG  = {"ASSIGNMENT", 48'h0};
  localparam logic [0:15][7:0] WORD_STU  = {"STUDENT", 72'h0};
  localparam logic [0:15][7:0] WORD_FPGA = {"FPGA", 96'h0};

  localparam logic [3:0] LEN_ENG  = 4'd11;
  localparam logic [3:0] LEN_ASG  = 4'd10;
  localparam logic [3:0] LEN_STU  = 4'd7;
  localparam logic [3:0] LEN_FPGA = 4'd4;

  localparam logic [1:0] ID_ENG  = 2'd0;
  localparam logic [1:0] ID_ASG  = 2'd1;
  localparam logic [1:0] ID_STU  = 2'd2;
  localparam logic [1:0] ID_FPGA = 2'd3;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  function automatic logic [7:0] word_char(input logic [1:0] id, input logic [3:0] idx);
    case (id)
      ID_ENG:  return WORD_ENG[idx];
      ID_ASG:  return WORD_ASG[idx];
      ID_STU:  return WORD_STU[idx];
      default: return WORD_FPGA[idx];
    endcase
  endfunction

  function automatic logic [3:0] word_len(input logic [1:0] id);
    case (id)
      ID_ENG:  return LEN_ENG;
      ID_ASG:  return LEN_ASG;
      ID_STU:  return LEN_STU;
      default: return LEN_FPGA;
    endcase
  endfunction

endpackage

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with mid-bit sampling.
// Ports:
//   sysclk     system clock
//   rst_n      async active-low reset
//   rx         raw serial line (idle high, asynchronous)
//   data[7:0]  last good byte, held until the next good byte
//   valid      one-cycle pulse when data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high while the receiver is not in IDLE
module serial_rx
  import word_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic       rx_meta, rxs;
  rx_state_t  state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [7:0] shreg, shreg_nxt, data_nxt;
  logic       valid_nxt, ferr_nxt;

  // 2-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + 16'd1;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    data_nxt   = data;
    valid_nxt  = 1'b0;
    ferr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        // half a bit in: confirm the start bit is still low
        if (timer == HALF_LAST) begin
          timer_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_nxt  = '0;
          shreg_nxt  = {rxs, shreg[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          if (rxs) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // park until the line releases so a held-low line reports once
        timer_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/word_rx.sv
// word_rx: UART receiver plus fixed-word recogniser.
// Recognises ENGINEERING / ASSIGNMENT / STUDENT / FPGA, each followed by a space.
// Build option: define WORD_RX_MATCH_EN to compile in the word matcher; without it
// word_hit and word_id are tied to 0.
// Ports:
//   sysclk, rst_n       clock, async active-low reset
//   rx                  serial line in
//   data, valid         received byte and its one-cycle strobe
//   frame_err           one-cycle pulse on a bad stop bit
//   busy                receiver not idle
//   word_hit, word_id   one-cycle hit pulse and matched word id (id held afterwards)
module word_rx
  import word_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic       word_hit,
  output logic [1:0] word_id
);

  serial_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

`ifdef WORD_RX_MATCH_EN
  logic [3:0]           idx;
  logic [NUM_WORDS-1:0] alive, char_ok, hit_vec;
  logic [1:0]           hit_id;

  // per-word lane: does this byte extend the match, and is the word complete
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    assign char_ok[w] = (idx < word_len(2'(w))) && (data == word_char(2'(w), idx));
    assign hit_vec[w] = alive[w] && (idx == word_len(2'(w)));
  end

  // lengths are distinct, so at most one lane can hit
  always_comb begin
    hit_id = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      if (hit_vec[w]) hit_id = 2'(w);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      alive    <= '1;
      word_hit <= 1'b0;
      word_id  <= '0;
    end else begin
      word_hit <= 1'b0;
      if (frame_err) begin
        idx   <= '0;
        alive <= '1;
      end else if (valid) begin
        if (data == ASCII_SPACE) begin
          word_hit <= |hit_vec;
          if (|hit_vec) word_id <= hit_id;
          idx   <= '0;
          alive <= '1;
        end else begin
          alive <= alive & char_ok;
          if (idx != 4'hF) idx <= idx + 4'd1;
        end
      end
    end
  end
`else
  assign word_hit = 1'b0;
  assign word_id  = 2'd0;
`endif

endmodule

// File: tb/tb_word_rx.sv
module tb_word_rx;

  localparam int CPB = 4;

`ifdef WORD_RX_MATCH_EN
  localparam bit MATCH = 1'b1;
`else
  localparam bit MATCH = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy, word_hit;
  logic [1:0] word_id;

  word_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .word_hit  (word_hit),
    .word_id   (word_id)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  string      words[4] = '{"ENGINEERING", "ASSIGNMENT", "STUDENT", "FPGA"};
  logic [7:0] mbuf[$];       // characters since last space / frame error / reset
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_hits[$];
  int         exp_ferr = 0;
  logic [7:0] last_good = 8'h00;

  function automatic int buf_word();
    string s;
    bit    ok;
    for (int w = 0; w < 4; w++) begin
      s = words[w];
      if (mbuf.size() == s.len()) begin
        ok = 1'b1;
        for (int i = 0; i < s.len(); i++)
          if (mbuf[i] != 8'(s[i])) ok = 1'b0;
        if (ok) return w;
      end
    end
    return -1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int w;
    exp_bytes.push_back(b);
    last_good = b;
    if (b == 8'h20) begin
      w = buf_word();
      if (w >= 0 && MATCH) exp_hits.push_back(2'(w));
      mbuf.delete();
    end else begin
      mbuf.push_back(b);
    end
  endfunction

  function automatic void model_ferr();
    exp_ferr++;
    mbuf.delete();
  endfunction

  function automatic void model_reset();
    mbuf.delete();
    last_good = 8'h00;
  endfunction

  // ---------------- monitor ----------------
  logic [7:0] got_bytes[$];
  logic [1:0] got_hits[$];
  int         got_ferr = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge sysclk) begin
    if (rst_n) begin
      if (valid) got_bytes.push_back(data);
      if (frame_err) got_ferr++;
      if (word_hit) begin
        chk("hit_after_space", {23'd0, prev_valid, prev_data}, {23'd0, 1'b1, 8'h20});
        got_hits.push_back(word_id);
      end
    end
    prev_valid = valid;
    prev_data  = data;
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // leaves rx at the stop level; caller decides what follows
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic send_ferr(input logic [7:0] b, input int hold);
    send_frame(b, 1'b0);
    tick(hold);
    rx = 1'b1;
    model_ferr();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(data), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_ferr"},  32'(frame_err), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_hit"},   32'(word_hit), 32'h0);
    chk({tag, "_id"},    32'(word_id), 32'h0);
  endtask

  // let the line go idle, then compare everything seen against the model
  task automatic settle(input string tag);
    int n;
    idle(3 * CPB + 6);
    chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
    chk({tag, "_nhits"}, 32'(got_hits.size()), 32'(exp_hits.size()));
    n = (got_hits.size() < exp_hits.size()) ? got_hits.size() : exp_hits.size();
    for (int i = 0; i < n; i++) chk({tag, "_hit_id"}, 32'(got_hits[i]), 32'(exp_hits[i]));
    chk({tag, "_nferr"}, 32'(got_ferr), 32'(exp_ferr));
    chk({tag, "_data_held"}, 32'(data), 32'(last_good));
    chk({tag, "_idle"}, 32'(busy), 32'h0);
    got_bytes.delete();
    exp_bytes.delete();
    got_hits.delete();
    exp_hits.delete();
    got_ferr = 0;
    exp_ferr = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    // single byte, with latency measured from the falling edge
    fork
      send_byte(8'h45);
      begin : lat
        int n;
        n = 0;
        while (!valid && n < 100) begin
          tick(1);
          n++;
        end
        chk("latency_in_window", 32'(n >= 39 && n <= 42), 32'h1);
      end
    join
    settle("byte45");

    send_str("FPGA ");
    settle("fpga");

    send_str("ENGINEERING ");
    send_str("STUDENT ");
    settle("eng_stu");

    send_str("FPGB ");
    send_str("FPGAA ");
    send_str(" ");
    send_str("FPGA ");
    settle("near_miss");

    // bad stop bit followed by a held-low line: exactly one frame_err
    send_ferr(8'h41, 40);
    idle(6);
    send_byte(8'h53);
    settle("frame_err");

    // one-cycle glitch is a false start
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    settle("glitch");

    // partial word, then reset mid-data-bit; matcher must forget "FPG"
    send_str("FPG");
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(2);
    chk("busy_mid_frame", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    got_bytes.delete();
    got_hits.delete();
    exp_bytes.delete();
    exp_hits.delete();
    tick(3);
    rst_n = 1'b1;
    settle("rst_abort");
    send_str("A ");
    settle("after_rst");

    // randomized mix of words, near-misses, noise and frame errors
    for (int k = 0; k < 30; k++) begin
      int         r, w, j;
      string      s;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 3);
      s = words[w];
      if (r <= 4) begin
        send_str(s);
        send_byte(8'h20);
      end else if (r <= 6) begin
        send_byte(8'($urandom_range(0, 255)));
      end else if (r == 7) begin
        send_byte(8'h20);
      end else if (r == 8) begin
        j = $urandom_range(0, s.len() - 1);
        for (int i = 0; i < s.len(); i++) begin
          c = 8'(s[i]);
          if (i == j) c = c ^ 8'h01;
          send_byte(c);
        end
        send_byte(8'h20);
      end else begin
        send_ferr(8'($urandom_range(0, 255)), $urandom_range(0, 20));
        idle(3);
      end
      idle($urandom_range(0, 2));
    end
    settle("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_rx.md
# word_rx

Serial receive block and word recogniser: the receive-side counterpart of the word-sequencing transmitter. It takes the 8N1 UART line, recovers bytes by mid-bit sampling and emits a one-cycle valid strobe per byte. It also matches the stream against the four fixed words ENGINEERING, ASSIGNMENT, STUDENT and FPGA, each terminated by a space (0x20). It sits between the board RX pin and the LED/status logic of the loop-back test.

## Interface
- CLKS_PER_BIT, 10416, sysclk cycles per bit period (100 MHz / 9600 baud); legal range 4..65535.
- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to sysclk.
- data  out  8  last good byte; holds until the next good byte.
- valid  out  1  one-cycle pulse when data is updated.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high whenever the receiver is not in IDLE.
- word_hit  out  1  one-cycle pulse when a complete word plus space has been received.
- word_id  out  2  0=ENGINEERING, 1=ASSIGNMENT, 2=STUDENT, 3=FPGA; valid with word_hit, held afterwards.

## Operation
- Reset values:
  - data=0x00, valid=0, frame_err=0, busy=0, word_hit=0, word_id=0.
  - Receiver state IDLE; synchroniser flops=1.
  - Matcher cleared: index=0, all four alive flags=1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Receiver FSM:
  - IDLE: on rxs=0, clear the bit-timer and go to START.
  - START: after CLKS_PER_BIT/2 (integer divide) cycles, re-sample.
    - rxs=1: false start, return to IDLE with no output.
    - rxs=0: go to DATA with bit count 0.
  - DATA: sample every CLKS_PER_BIT cycles. Shift LSB first into the shift register. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1: data<=shift register, valid pulse, go to IDLE.
    - rxs=0: frame_err pulse, data unchanged, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. Guarantees a held-low line yields exactly one frame_err.
- Bit timer is 16-bit and counts 0..CLKS_PER_BIT-1, then wraps to 0 at each sample.
- Matcher, updated in the cycle valid is high:
  - Byte = 0x20: if index equals the length of a word (11/10/7/4) whose alive flag is set, pulse word_hit with that word's id. Then index<=0 and all alive<=1. A lone space or a space after a mismatch produces no hit.
  - Any other byte: for each word w, alive[w] <= alive[w] & (index < len[w]) & (byte == word[w][index]). index increments, saturating at 15.
  - frame_err clears the matcher to its reset state.
- Hits are unambiguous: word lengths differ, so at most one word can hit.

## Timing
- Sync latency: 2 cycles from an rx edge to rxs.
- valid rises in the cycle after the stop-bit sample. For a clean start edge this is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the rx falling edge.
- word_hit is registered: it asserts exactly 1 cycle after the valid pulse of the terminating space.
- Back-to-back frames: a start bit immediately after the stop sample must be caught. IDLE is entered in the same cycle valid asserts.
- rst_n asserted mid-frame: all outputs go to reset values immediately. The partial byte is discarded and no valid is emitted. After release the block waits for the next falling edge.

## Configuration
- WORD_RX_MATCH_EN defined: matcher compiled in as described.
- Not defined: matcher removed; word_hit tied 0 and word_id tied 0. Byte receive behaviour is unchanged.

## Structure
- Package word_rx_pkg holds:
  - ASCII constants for the four words and space.
  - Word length constants 11/10/7/4.
  - word_id encodings.
  - Receiver state enum (IDLE, START, DATA, STOP, BREAK).
- Sub-module serial_rx holds the synchroniser, bit timer and receiver FSM, with outputs data/valid/frame_err/busy. The word matcher lives in word_rx.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Send 0x45 framed 8N1 -> exactly one valid pulse, data=0x45, frame_err never asserted.
- Send "FPGA " as consecutive frames -> five valid pulses; word_hit 1 cycle after the 0x20 valid; word_id=3.
- Send "ENGINEERING " then "STUDENT " back-to-back -> word_hit with id 0, then word_hit with id 2; no other hits.
- Send "FPGB " and "FPGAA " -> no word_hit. A following "FPGA " -> hit with id 3.
- Send 0x41 with stop bit=0, then hold rx low 40 cycles -> one frame_err, no valid, data unchanged. After rx returns high, a 0x53 frame -> valid, data=0x53.
- Glitch: rx low 1 cycle -> no valid (false start). Assert rst_n low mid-data-bit -> outputs at reset values, no valid for the aborted frame.
